sdram_readback_checker: RTL and testbench

Read-side companion to the counter-ramp SDRAM writer: drains one frame from the `Sdram_Control` read FIFO port (RD1) and verifies it against the ramp pattern the writer produced. The expected ramp is zero-extended (BASE + index) mod 2^CNT_W. It reports pass/fail, the mismatch count and the first failing word. It sits beside the writer in the SDRAM test top and runs in the host clock domain.

---
 rtl/sdram_chk_pkg.sv | 15 +
 rtl/ramp_pattern_gen.sv | 29 ++
 rtl/sdram_readback_checker.sv | 114 +++++++++++
 tb/tb_sdram_readback_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_chk_pkg.sv
// sdram_chk_pkg: state encoding and default widths shared by the SDRAM ramp writer and readback checker.
package sdram_chk_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ramp_pattern_gen.sv
// ramp_pattern_gen: zero-extended (BASE + n) mod 2^CNT_W ramp, restarted by clear and stepped by advance.
module ramp_pattern_gen
    import sdram_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int BASE   = 0
) (
    input  logic              clk_27m,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [DATA_W-1:0] exp
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n)
            cnt <= CNT_W'(BASE);
        else if (clear)
            cnt <= CNT_W'(BASE);
        else if (advance)
            cnt <= cnt + 1'b1;
    end

    assign exp = DATA_W'(cnt);

endmodule

// File: rtl/sdram_readback_checker.sv
// sdram_readback_checker: drains one frame from the SDRAM read FIFO and checks it against the writer's ramp.
module sdram_readback_checker
    import sdram_chk_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WORDS    = 256,
    parameter int BASE     = 0,
    parameter int LOAD_CYC = 4
) (
    input  logic                         REF_CLK,
    input  logic                         RESET_N,
    input  logic                         START,
    output logic                         RD_LOAD,
    output logic                         RD,
    input  logic                         RD_EMPTY,
    input  logic [DATA_W-1:0]            RD_DATA,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         PASS,
    output logic [$clog2(WORDS+1)-1:0]   ERR_COUNT,
    output logic [$clog2(WORDS)-1:0]     FIRST_ERR_IDX,
    output logic [DATA_W-1:0]            FIRST_ERR_DATA
);

    localparam int EW = $clog2(WORDS + 1);
    localparam int IW = $clog2(WORDS);
    localparam int LW = $clog2(LOAD_CYC + 1);

    state_t            state;
    logic              armed;
    logic              rd_q;
    logic [LW-1:0]     load_cnt;
    logic [EW-1:0]     issued;
    logic [EW-1:0]     cmp_idx;
    logic [DATA_W-1:0] exp_word;
    logic              start_ok;
    logic              mismatch;

    // armed blocks a START sampled on the first edge after reset release
    assign start_ok = START && armed;
    assign RD       = state == ST_READ && !RD_EMPTY && issued < EW'(WORDS);
    assign BUSY     = state inside {ST_LOAD, ST_READ, ST_DRAIN};
    assign DONE     = state == ST_DONE;
    assign PASS     = DONE && ERR_COUNT == '0;
    assign mismatch = rd_q && RD_DATA != exp_word;

    ramp_pattern_gen #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .BASE   (BASE)
    ) u_ramp (
        .clk_27m (REF_CLK),
        .rst_n   (RESET_N),
        .clear   (start_ok && !BUSY),
        .advance (rd_q),
        .exp     (exp_word)
    );

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_IDLE;
            armed          <= 1'b0;
            rd_q           <= 1'b0;
            RD_LOAD        <= 1'b0;
            load_cnt       <= '0;
            issued         <= '0;
            cmp_idx        <= '0;
            ERR_COUNT      <= '0;
            FIRST_ERR_IDX  <= '0;
            FIRST_ERR_DATA <= '0;
        end else begin
            armed <= 1'b1;
            rd_q  <= RD;
            if (RD)
                issued <= issued + 1'b1;
            if (rd_q)
                cmp_idx <= cmp_idx + 1'b1;
            if (mismatch) begin
                ERR_COUNT <= ERR_COUNT + 1'b1;
                if (ERR_COUNT == '0) begin
                    FIRST_ERR_IDX  <= cmp_idx[IW-1:0];
                    FIRST_ERR_DATA <= RD_DATA;
                end
            end
            case (state)
                ST_IDLE, ST_DONE: if (start_ok) begin
                    state          <= ST_LOAD;
                    RD_LOAD        <= 1'b1;
                    load_cnt       <= '0;
                    issued         <= '0;
                    cmp_idx        <= '0;
                    ERR_COUNT      <= '0;
                    FIRST_ERR_IDX  <= '0;
                    FIRST_ERR_DATA <= '0;
                end
                ST_LOAD: begin
                    load_cnt <= load_cnt + 1'b1;
                    if (load_cnt == LW'(LOAD_CYC - 1)) begin
                        state   <= ST_READ;
                        RD_LOAD <= 1'b0;
                    end
                end
                ST_READ: if (RD && issued == EW'(WORDS - 1))
                    state <= ST_DRAIN;
                // finish on the edge that retires the last compare so DONE trails the last RD by two cycles
                ST_DRAIN: if (cmp_idx == EW'(WORDS) || (rd_q && cmp_idx == EW'(WORDS - 1)))
                    state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_readback_checker.sv
// tb_sdram_readback_checker: FIFO-model scoreboard bench for the SDRAM readback checker (BASE 0 and BASE 0xF0 instances).
module tb_sdram_readback_checker;

    typedef struct {
        logic        pass;
        int          errc;
        int          fidx;
        logic [15:0] fdat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start   [2];
    logic        rd_load [2];
    logic        rd      [2];
    logic        empty   [2];
    logic [15:0] data    [2];
    logic        busy    [2];
    logic        done    [2];
    logic        pass    [2];
    logic [8:0]  errc    [2];
    logic [7:0]  fidx    [2];
    logic [15:0] fdat    [2];

    logic [15:0] mem [256];
    logic [7:0]  ptr   [2];
    int          reads [2];
    int          viol  [2];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    sdram_readback_checker #(.BASE(0)) dut0 (
        .REF_CLK(clk), .RESET_N(rst_n), .START(start[0]), .RD_LOAD(rd_load[0]), .RD(rd[0]),
        .RD_EMPTY(empty[0]), .RD_DATA(data[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .ERR_COUNT(errc[0]), .FIRST_ERR_IDX(fidx[0]), .FIRST_ERR_DATA(fdat[0])
    );

    sdram_readback_checker #(.BASE(8'hF0)) dut1 (
        .REF_CLK(clk), .RESET_N(rst_n), .START(start[1]), .RD_LOAD(rd_load[1]), .RD(rd[1]),
        .RD_EMPTY(empty[1]), .RD_DATA(data[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .ERR_COUNT(errc[1]), .FIRST_ERR_IDX(fidx[1]), .FIRST_ERR_DATA(fdat[1])
    );

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rd_load[u]) begin
                ptr[u]   <= 8'd0;
                reads[u] <= 0;
            end else if (rd[u]) begin
                data[u]  <= mem[ptr[u]];
                ptr[u]   <= ptr[u] + 8'd1;
                reads[u] <= reads[u] + 1;
            end
            if (rd[u] && empty[u])
                viol[u] <= viol[u] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic fill_ramp(input logic [7:0] base);
        for (int i = 0; i < 256; i++)
            mem[i] = {8'h00, base + 8'(i)};
    endtask

    task automatic run(input int u, input bit rnd, input bit mid_start, input bit chk_lat);
        exp_t        e;
        int          cyc;
        logic [7:0]  base;
        logic [15:0] want;
        base = (u == 1) ? 8'hF0 : 8'h00;
        e = '{pass: 1'b1, errc: 0, fidx: 0, fdat: 16'h0};
        for (int i = 0; i < 256; i++) begin
            want = {8'h00, base + 8'(i)};
            if (mem[i] !== want) begin
                if (e.errc == 0) begin
                    e.fidx = i;
                    e.fdat = mem[i];
                end
                e.errc++;
                e.pass = 1'b0;
            end
        end
        sb.push_back(e);
        viol[u] = 0;
        @(negedge clk) start[u] = 1'b1;
        @(negedge clk) start[u] = 1'b0;
        check("rd_load_after_start", 32'(rd_load[u]), 32'd1);
        check("done_cleared", 32'(done[u]), 32'd0);
        check("err_cleared", 32'(errc[u]), 32'd0);
        cyc = 1;
        while (!done[u] && cyc < 3000) begin
            empty[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mid_start)
                start[u] = (cyc == 60);
            @(negedge clk);
            cyc++;
        end
        empty[u] = 1'b0;
        start[u] = 1'b0;
        e = sb.pop_front();
        check("done_reached", 32'(done[u]), 32'd1);
        if (chk_lat)
            check("done_latency", 32'(cyc), 32'(4 + 256 + 2));
        check("pass", 32'(pass[u]), 32'(e.pass));
        check("err_count", 32'(errc[u]), 32'(e.errc));
        check("first_err_idx", 32'(fidx[u]), 32'(e.fidx));
        check("first_err_data", 32'(fdat[u]), 32'(e.fdat));
        check("read_count", 32'(reads[u]), 32'd256);
        check("rd_while_empty", 32'(viol[u]), 32'd0);
        check("busy_at_done", 32'(busy[u]), 32'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            empty[u] = 1'b0;
            reads[u] = 0;
            viol[u]  = 0;
        end
        fill_ramp(8'h00);
        repeat (3) @(negedge clk);
        check("reset_rd", 32'(rd[0]), 32'd0);
        check("reset_rd_load", 32'(rd_load[0]), 32'd0);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_done", 32'(done[0]), 32'd0);
        check("reset_pass", 32'(pass[0]), 32'd0);
        check("reset_err", 32'(errc[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b0, 1'b0, 1'b1);
        mem[8'h37] = 16'hAB37;
        mem[8'h80] = 16'h0000;
        run(0, 1'b0, 1'b0, 1'b1);
        fill_ramp(8'h00);
        run(0, 1'b1, 1'b0, 1'b0);
        run(0, 1'b0, 1'b1, 1'b1);
        fill_ramp(8'hF0);
        check("wrapped_word_0x10", 32'(mem[8'h10]), 32'h0);
        run(1, 1'b0, 1'b0, 1'b1);
        fill_ramp(8'h00);
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        w = 0;
        while (reads[0] != 100 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("reached_100th_read", 32'(reads[0]), 32'd100);
        rst_n = 1'b0;
        #1;
        check("rst_rd", 32'(rd[0]), 32'd0);
        check("rst_rd_load", 32'(rd_load[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_pass", 32'(pass[0]), 32'd0);
        check("rst_err", 32'(errc[0]), 32'd0);
        check("rst_fidx", 32'(fidx[0]), 32'd0);
        check("rst_fdat", 32'(fdat[0]), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_release_busy", 32'(busy[0]), 32'd0);
        check("idle_after_release_load", 32'(rd_load[0]), 32'd0);
        check("idle_after_release_done", 32'(done[0]), 32'd0);
        run(0, 1'b0, 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
